uart_tx_fifo: RTL and testbench
===============================

# uart_tx_fifo

Buffered UART transmitter: accepts bytes on a valid/ready stream, queues them in an internal FIFO, and serializes them as 8N1 frames on `tx`. It sits between a byte producer with no backpressure (such as the UART receiver in an echo or loopback path) and the serial line. It absorbs bursts up to the FIFO depth, and it flags any byte lost because the FIFO was full.

## Interface

Parameters:
- `WTIME`, default 16'h0365: bit period minus one, in `clk` cycles. Each bit is held for WTIME+1 cycles. Must be ≥ 1.
- `DEPTH_LOG2`, default 4: FIFO depth is 2**DEPTH_LOG2 entries (16 by default).

Ports:
- `clk`  in  1  sole clock; all state updates on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `in_data`  in  8  byte to transmit.
- `in_valid`  in  1  `in_data` is valid this cycle.
- `in_ready`  out  1  FIFO can accept a byte; equals not-full.
- `tx`  out  1  serial output. Idle high, start bit low, 8 data bits LSB first, stop bit high.
- `busy`  out  1  a frame is in progress, or the FIFO is non-empty.
- `count`  out  DEPTH_LOG2+1  FIFO occupancy, 0..2**DEPTH_LOG2.
- `overflow`  out  1  sticky flag: a byte was presented while full and was dropped.

## Operation

- **Reset values:** `tx`=1, `count`=0, `in_ready`=1, `busy`=0, `overflow`=0, FSM in IDLE, FIFO pointers 0.
- **Push:** when `in_valid && in_ready`, `in_data` is written at the write pointer, the write pointer increments modulo depth, and `count` increments.
- **Drop:** when `in_valid && !in_ready`, the byte is discarded, `overflow` is set to 1, and it stays 1 until `reset`.
- **Full condition:** `in_ready` is computed from the current `count` only. A pop in the same cycle does not make room for a push while full.
- **Pointers:** read and write pointers are DEPTH_LOG2 bits wide and wrap naturally. Full/empty is decided by `count`, not by pointer comparison.
- **Simultaneous push and pop:** `count` is unchanged; both pointers advance.
- **FSM states:**
  - IDLE: `tx`=1. If `count`≠0, pop the head. Load the 10-bit shift register with {1, data, 0}, set bit index to 0, set the bit counter to WTIME, and go to SEND. If `count`=0, stay in IDLE.
  - SEND: `tx` is shift register bit 0, driven from a register. The counter decrements each cycle.
    - At counter==0 with bit index 9 (stop bit done): go to IDLE.
    - At counter==0 otherwise: shift right with 1 fill, increment bit index, reload the counter with WTIME.
- **Empty-FIFO pop:** a byte pushed into an empty FIFO cannot be popped in the same cycle. The pop happens in the following cycle.
- **`busy`:** equals (state ≠ IDLE) || (`count` ≠ 0), driven combinationally from registers.
- **Width rules:** `count` never exceeds 2**DEPTH_LOG2 and never goes below 0. The bit counter is 16 bits wide.
- **Reset mid-frame:** the frame is abandoned. `tx` returns to 1 on the cycle after the reset edge, and FIFO contents are discarded (count=0).

## Timing

- **Push visibility:** a byte accepted at edge N shows in `count` after edge N.
- **Empty-FIFO latency:** if the FSM is IDLE and the FIFO was empty, the pop occurs at edge N+1 and `tx` falls after edge N+2.
- **Bit timing:** each of the 10 bits is held exactly WTIME+1 cycles. A frame therefore occupies 10·(WTIME+1) cycles.
- **Back-to-back frames:** IDLE lasts exactly one cycle between frames. Stop-bit end to the next start-bit falling edge is 1 cycle, so frame-to-frame pitch is 10·(WTIME+1)+1 cycles.
- **`in_ready`:** falls in the cycle after the push that makes `count`=depth. It rises in the cycle after the pop that leaves `count`=depth−1.
- **`overflow`:** rises the cycle after the first dropped byte.

## Test plan

Use WTIME=3 (4 cycles/bit) and DEPTH_LOG2=2 (depth 4) unless noted.

1. **Reset state:** assert `reset` for 2 cycles. Required: `tx`=1, `count`=0, `in_ready`=1, `busy`=0, `overflow`=0.
2. **Single byte:** push 8'hA5 once. Required:
   - `tx` falls 2 cycles after acceptance.
   - Sampled at bit centers: 0,1,0,1,0,0,1,0,1,1.
   - Each level is held 4 cycles, 40 cycles total.
   - `busy` drops the cycle after the stop bit ends.
3. **Burst of four:** push 8'h01, 8'h02, 8'h03, 8'h04 on consecutive cycles. Required:
   - Four frames in order with a 41-cycle pitch.
   - `in_ready` stays 1 throughout, and `count` peaks at 3.
4. **Overflow:** with the FSM busy, push six bytes 8'h10..8'h15 on consecutive cycles. Required:
   - `in_ready`=0 once `count`=4.
   - 8'h15 is dropped and `overflow`=1 and stays 1.
   - Transmitted order is 8'h10..8'h14, with no corruption after pointer wrap.
5. **Reset mid-frame:** push 8'hFF then 8'h00. Assert `reset` during bit 3 of the first frame. Required:
   - `tx`=1 the next cycle.
   - `count`=0, `overflow`=0.
   - No further frames are emitted.
6. **Default timing and wrap:** use default WTIME=16'h0365 and depth 16. Stream 40 bytes with a gap of one frame time. Required: every bit lasts 870 cycles, and the 40 bytes are received intact through multiple pointer wraps.

Source files
------------

// File: rtl/uart_tx_fifo.sv
// Buffered 8N1 UART transmitter: a byte FIFO feeding a shift-register serializer.
// Bytes arriving while the FIFO is full are dropped and latched in a sticky overflow flag.
module uart_tx_fifo #(
  parameter logic [15:0] WTIME      = 16'h0365,
  parameter int          DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [7:0]            in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic                  tx,
  output logic                  busy,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  overflow
);

  localparam int                  DEPTH    = 2**DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  typedef enum logic {IDLE, SEND} state_t;

  state_t                  state_q, state_d;
  logic [7:0]              mem [DEPTH];
  logic [DEPTH_LOG2-1:0]   wptr, rptr;
  logic [9:0]              shreg;
  logic [3:0]              bit_idx;
  logic [15:0]             bit_cnt;
  logic                    push, drop, pop, shift_en, tick, tx_d;

  assign in_ready = (count != CNT_FULL);
  assign busy     = (state_q != IDLE) || (count != '0);
  assign push     = in_valid && in_ready;
  assign drop     = in_valid && !in_ready;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (count != '0) state_d = SEND;
      SEND:    if (bit_cnt == 16'd0 && bit_idx == 4'd9) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Pop only looks at the registered count, so a byte pushed into an empty
  // FIFO is picked up one cycle later.
  always_comb begin
    pop      = 1'b0;
    shift_en = 1'b0;
    tick     = 1'b0;
    tx_d     = 1'b1;
    case (state_q)
      IDLE: pop = (count != '0);
      SEND: begin
        tx_d     = shreg[0];
        tick     = (bit_cnt != 16'd0);
        shift_en = (bit_cnt == 16'd0) && (bit_idx != 4'd9);
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wptr     <= '0;
      rptr     <= '0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      if (push) wptr <= wptr + (DEPTH_LOG2)'(1);
      if (pop)  rptr <= rptr + (DEPTH_LOG2)'(1);
      case ({push, pop})
        2'b10:   count <= count + (DEPTH_LOG2+1)'(1);
        2'b01:   count <= count - (DEPTH_LOG2+1)'(1);
        default: count <= count;
      endcase
      if (drop) overflow <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wptr] <= in_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      bit_idx <= 4'd0;
      bit_cnt <= 16'd0;
      tx      <= 1'b1;
    end else begin
      tx <= tx_d;
      if (pop) begin
        bit_idx <= 4'd0;
        bit_cnt <= WTIME;
      end else if (shift_en) begin
        bit_idx <= bit_idx + 4'd1;
        bit_cnt <= WTIME;
      end else if (tick) begin
        bit_cnt <= bit_cnt - 16'd1;
      end
    end
  end

  // Frame image {stop, data, start} goes out LSB first; vacated bits fill with idle level.
  always_ff @(posedge clk) begin
    if (pop)           shreg <= {1'b1, mem[rptr], 1'b0};
    else if (shift_en) shreg <= {1'b1, shreg[9:1]};
  end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: three instances (small fast, default timing, deep FIFO)
// with a line decoder per instance and a transaction-level queue model.
module tb_uart_tx_fifo;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       a_reset, a_valid, a_ready, a_tx, a_busy, a_ovf;
  logic [7:0] a_data;
  logic [2:0] a_count;
  logic       bc_reset;
  logic       b_valid, b_ready, b_tx, b_busy, b_ovf;
  logic [7:0] b_data;
  logic [4:0] b_count;
  logic       c_valid, c_ready, c_tx, c_busy, c_ovf;
  logic [7:0] c_data;
  logic [4:0] c_count;

  uart_tx_fifo #(.WTIME(16'd3), .DEPTH_LOG2(2)) dut_a (
    .clk(clk), .reset(a_reset), .in_data(a_data), .in_valid(a_valid), .in_ready(a_ready),
    .tx(a_tx), .busy(a_busy), .count(a_count), .overflow(a_ovf));

  uart_tx_fifo dut_b (
    .clk(clk), .reset(bc_reset), .in_data(b_data), .in_valid(b_valid), .in_ready(b_ready),
    .tx(b_tx), .busy(b_busy), .count(b_count), .overflow(b_ovf));

  uart_tx_fifo #(.WTIME(16'd1), .DEPTH_LOG2(4)) dut_c (
    .clk(clk), .reset(bc_reset), .in_data(c_data), .in_valid(c_valid), .in_ready(c_ready),
    .tx(c_tx), .busy(c_busy), .count(c_count), .overflow(c_ovf));

  int n_vec = 0;
  int n_err = 0;
  int cyc   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s (cycle %0d): got %0h, expected %0h", name, cyc, act, exp);
    end
  endtask

  // Line decoders: one per instance, sampling tx 1 time unit after every rising edge
  int         per [3] = '{4, 870, 2};
  logic       act [3] = '{1'b0, 1'b0, 1'b0};
  int         pos [3];
  int         t0  [3];
  logic [7:0] shv [3];
  logic       cur [3];
  logic       werr[3];
  logic [7:0] rxq [3][$];
  int         rxt [3][$];

  task automatic rx_sample(input int id, input logic txv);
    int k;
    if (!act[id]) begin
      if (txv === 1'b0) begin
        act[id] = 1'b1; pos[id] = 0; t0[id] = cyc; werr[id] = 1'b0; cur[id] = 1'b0;
      end
    end else begin
      pos[id]++;
      k = pos[id] / per[id];
      if (pos[id] % per[id] == 0) begin
        cur[id] = txv;
        if (k >= 1 && k <= 8) shv[id][k-1] = txv;
      end else if (txv !== cur[id]) begin
        werr[id] = 1'b1;
      end
      if (k == 9 && txv !== 1'b1) werr[id] = 1'b1;
      if (pos[id] == 10*per[id] - 1) begin
        act[id] = 1'b0;
        rxq[id].push_back(shv[id]);
        rxt[id].push_back(t0[id]);
        chk($sformatf("rx%0d frame shape", id), 32'(werr[id]), 32'd0);
      end
    end
  endtask

  initial begin
    forever begin
      @(posedge clk);
      cyc++;
      #1;
      rx_sample(0, a_tx);
      rx_sample(1, b_tx);
      rx_sample(2, c_tx);
    end
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic at(input int t);
    while (cyc < t) step();
  endtask

  typedef struct {
    logic [7:0] data;
    logic [9:0] bits;
  } frame_vec_t;

  frame_vec_t tbl [4];

  // Transaction-level reference for instance C
  logic [7:0] mq [$];
  logic [7:0] exp_c [$];
  int         exp_ct [$];

  initial begin
    int n, n2, peak, low, next_ok, fsm_until, cnt_now;
    logic rdy_lo, movf, v, do_pop, busy_exp;
    logic [7:0] d;

    a_reset = 1'b1; bc_reset = 1'b1;
    a_valid = 1'b0; b_valid = 1'b0; c_valid = 1'b0;
    a_data = 8'h00; b_data = 8'h00; c_data = 8'h00;
    step(); step();
    a_reset = 1'b0; bc_reset = 1'b0;

    // Reset state
    chk("reset tx", 32'(a_tx), 32'd1);
    chk("reset count", 32'(a_count), 32'd0);
    chk("reset in_ready", 32'(a_ready), 32'd1);
    chk("reset busy", 32'(a_busy), 32'd0);
    chk("reset overflow", 32'(a_ovf), 32'd0);

    // Single-byte frames, sampled at bit centres
    tbl[0] = '{8'hA5, 10'b1101001010};
    tbl[1] = '{8'h00, 10'b1000000000};
    tbl[2] = '{8'hFF, 10'b1111111110};
    tbl[3] = '{8'h3C, 10'b1001111000};
    for (int i = 0; i < 4; i++) begin
      a_data = tbl[i].data; a_valid = 1'b1;
      step();
      a_valid = 1'b0;
      n = cyc;
      chk("single count after push", 32'(a_count), 32'd1);
      at(n+1);
      chk("single tx before fall", 32'(a_tx), 32'd1);
      chk("single count after pop", 32'(a_count), 32'd0);
      at(n+2);
      chk("single tx falls", 32'(a_tx), 32'd0);
      for (int k = 0; k < 10; k++) begin
        at(n + 4 + 4*k);
        chk($sformatf("frame %0h bit %0d", tbl[i].data, k), 32'(a_tx), 32'(tbl[i].bits[k]));
      end
      at(n+40);
      chk("single busy in stop", 32'(a_busy), 32'd1);
      at(n+41);
      chk("single busy drops", 32'(a_busy), 32'd0);
      step(); step();
    end
    chk("single rx count", 32'(rxq[0].size()), 32'd4);
    for (int i = 0; i < 4 && i < rxq[0].size(); i++)
      chk("single rx byte", 32'(rxq[0][i]), 32'(tbl[i].data));
    rxq[0].delete(); rxt[0].delete();

    // Burst of four
    peak = 0; rdy_lo = 1'b0;
    for (int j = 0; j < 4; j++) begin
      if (!a_ready) rdy_lo = 1'b1;
      a_data = 8'(j + 1); a_valid = 1'b1;
      step();
      if (j == 0) n = cyc;
      if (int'(a_count) > peak) peak = int'(a_count);
    end
    a_valid = 1'b0;
    for (int j = 0; j < 170; j++) begin
      step();
      if (int'(a_count) > peak) peak = int'(a_count);
      if (!a_ready) rdy_lo = 1'b1;
    end
    chk("burst count peak", 32'(peak), 32'd3);
    chk("burst in_ready low seen", 32'(rdy_lo), 32'd0);
    chk("burst rx count", 32'(rxq[0].size()), 32'd4);
    if (rxq[0].size() == 4) begin
      chk("burst first start", 32'(rxt[0][0]), 32'(n + 2));
      for (int j = 0; j < 4; j++) chk("burst rx byte", 32'(rxq[0][j]), 32'(j + 1));
      for (int j = 0; j < 3; j++) chk("burst pitch", 32'(rxt[0][j+1] - rxt[0][j]), 32'd41);
    end
    rxq[0].delete(); rxt[0].delete();

    // Overflow
    for (int j = 0; j < 6; j++) begin
      a_data = 8'(8'h10 + j); a_valid = 1'b1;
      step();
      if (j == 0) n = cyc;
      if (j == 3) begin
        chk("ovf count at 3", 32'(a_count), 32'd3);
        chk("ovf ready at 3", 32'(a_ready), 32'd1);
      end
      if (j == 4) begin
        chk("ovf count full", 32'(a_count), 32'd4);
        chk("ovf ready full", 32'(a_ready), 32'd0);
        chk("ovf flag before drop", 32'(a_ovf), 32'd0);
      end
      if (j == 5) begin
        chk("ovf count after drop", 32'(a_count), 32'd4);
        chk("ovf flag rises", 32'(a_ovf), 32'd1);
      end
    end
    a_valid = 1'b0;
    at(n+41);
    chk("ovf ready still low", 32'(a_ready), 32'd0);
    at(n+42);
    chk("ovf count after pop", 32'(a_count), 32'd3);
    chk("ovf ready rises", 32'(a_ready), 32'd1);
    at(n+220);
    chk("ovf flag sticky", 32'(a_ovf), 32'd1);
    chk("ovf rx count", 32'(rxq[0].size()), 32'd5);
    for (int j = 0; j < 5 && j < rxq[0].size(); j++)
      chk("ovf rx byte", 32'(rxq[0][j]), 32'(8'h10 + j));
    rxq[0].delete(); rxt[0].delete();

    // Reset mid-frame
    a_data = 8'hFF; a_valid = 1'b1;
    step();
    n = cyc;
    a_data = 8'h00;
    step();
    a_valid = 1'b0;
    at(n+14);
    a_reset = 1'b1;
    step();
    a_reset = 1'b0;
    chk("midreset tx", 32'(a_tx), 32'd1);
    chk("midreset count", 32'(a_count), 32'd0);
    chk("midreset overflow", 32'(a_ovf), 32'd0);
    chk("midreset busy", 32'(a_busy), 32'd0);
    chk("midreset in_ready", 32'(a_ready), 32'd1);
    low = 0;
    for (int j = 0; j < 80; j++) begin
      step();
      if (a_tx !== 1'b1) low++;
    end
    chk("midreset no further frames", 32'(low), 32'd0);
    chk("midreset count stays 0", 32'(a_count), 32'd0);

    // Default timing
    b_data = 8'hA5; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    n = cyc;
    at(n+1);
    chk("dflt popped", 32'(b_count), 32'd0);
    at(n+2);
    chk("dflt tx falls", 32'(b_tx), 32'd0);
    at(n+871);
    chk("dflt start bit end", 32'(b_tx), 32'd0);
    at(n+872);
    chk("dflt bit1 begins", 32'(b_tx), 32'd1);
    at(n+8700);
    chk("dflt busy in stop", 32'(b_busy), 32'd1);
    at(n+8701);
    chk("dflt busy drops", 32'(b_busy), 32'd0);
    at(n+8701+8700);
    b_data = 8'h3C; b_valid = 1'b1;
    step();
    b_valid = 1'b0;
    n2 = cyc;
    at(n2+2);
    chk("dflt second tx falls", 32'(b_tx), 32'd0);
    at(n2+8705);
    chk("dflt rx count", 32'(rxq[1].size()), 32'd2);
    if (rxq[1].size() == 2) begin
      chk("dflt rx byte0", 32'(rxq[1][0]), 32'h0A5);
      chk("dflt rx byte1", 32'(rxq[1][1]), 32'h03C);
      chk("dflt start0", 32'(rxt[1][0]), 32'(n + 2));
      chk("dflt start1", 32'(rxt[1][1]), 32'(n2 + 2));
    end

    // Randomized traffic on the deep FIFO against the queue model
    next_ok = 0; fsm_until = 0; movf = 1'b0;
    for (int j = 0; j < 1700; j++) begin
      if (j >= 1300)                 v = 1'b0;
      else if (j >= 300 && j < 340)  v = 1'b1;
      else                           v = ($urandom_range(0, 24) == 0);
      d = 8'($urandom);
      c_valid = v; c_data = d;
      step();
      cnt_now = mq.size();
      do_pop = (cnt_now > 0) && (cyc >= next_ok);
      if (do_pop) begin
        exp_c.push_back(mq.pop_front());
        exp_ct.push_back(cyc + 1);
        next_ok   = cyc + 21;
        fsm_until = cyc + 20;
      end
      if (v && cnt_now < 16) mq.push_back(d);
      if (v && cnt_now == 16) movf = 1'b1;
      busy_exp = (cyc < fsm_until) || (mq.size() != 0);
      chk("rand state {count,ready,ovf,busy}",
          32'({c_count, c_ready, c_ovf, c_busy}),
          32'({5'(mq.size()), (mq.size() < 16), movf, busy_exp}));
    end
    c_valid = 1'b0;
    chk("rand rx count", 32'(rxq[2].size()), 32'(exp_c.size()));
    for (int j = 0; j < exp_c.size() && j < rxq[2].size(); j++) begin
      chk("rand rx byte", 32'(rxq[2][j]), 32'(exp_c[j]));
      chk("rand rx start", 32'(rxt[2][j]), 32'(exp_ct[j]));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
